// File: rtl/game_countdown.sv
// game_countdown: M:SS.t BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// The count decrements one tenth per tick while running and stops at 0:00.0.
// Every output is a flop, so none of them follows rst or the inputs combinationally.
module game_countdown #(
  parameter int MAX_MIN = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic       start,
  input  logic       tick,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  localparam logic [3:0] MaxMin = 4'(MAX_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] nextMin, nextTens, nextOnes, nextTenths;
  logic       isZero, lastTenth;
  logic [3:0] loadClamped;

  // Preset value: anything above MaxMin, including non-BCD codes, saturates.
  assign loadClamped = (load_min > MaxMin) ? MaxMin : load_min;

  assign isZero    = (min_bcd == 4'd0) && (sec_tens == 4'd0) &&
                     (sec_ones == 4'd0) && (tenths == 4'd0);
  assign lastTenth = (min_bcd == 4'd0) && (sec_tens == 4'd0) &&
                     (sec_ones == 4'd0) && (tenths == 4'd1);

  // One-tenth decrement with the borrow rippling tenths -> ones -> tens -> minutes.
  always_comb begin
    nextMin    = min_bcd;
    nextTens   = sec_tens;
    nextOnes   = sec_ones;
    nextTenths = tenths;
    if (tenths != 4'd0) begin
      nextTenths = tenths - 4'd1;
    end else begin
      nextTenths = 4'd9;
      if (sec_ones != 4'd0) begin
        nextOnes = sec_ones - 4'd1;
      end else begin
        nextOnes = 4'd9;
        if (sec_tens != 4'd0) begin
          nextTens = sec_tens - 4'd1;
        end else begin
          nextTens = 4'd5;
          nextMin  = min_bcd - 4'd1;
        end
      end
    end
  end

  // Control FSM and count registers; priority rst > load > start > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      min_bcd  <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      tenths   <= 4'd0;
      running  <= 1'b0;
      expired  <= 1'b0;
      time_up  <= 1'b0;
    end else begin
      time_up <= 1'b0;
      if (load) begin
        state    <= IDLE;
        min_bcd  <= loadClamped;
        sec_tens <= 4'd0;
        sec_ones <= 4'd0;
        tenths   <= 4'd0;
        running  <= 1'b0;
        expired  <= 1'b0;
      end else if (start) begin
        // A same-cycle tick is dropped: the toggle alone takes effect.
        case (state)
          IDLE: begin
            if (!isZero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          PAUSE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          default: ;
        endcase
      end else if (tick && state == RUN && !isZero) begin
        min_bcd  <= nextMin;
        sec_tens <= nextTens;
        sec_ones <= nextOnes;
        tenths   <= nextTenths;
        if (lastTenth) begin
          state   <= EXPIRED;
          running <= 1'b0;
          expired <= 1'b1;
          time_up <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_countdown.sv
// tb_game_countdown: directed scenarios plus random traffic; a model counting
// in plain tenths-of-a-second predicts every cycle's outputs into a queue that
// a separate monitor drains and compares.
module tb_game_countdown;

  localparam int MAX_MIN = 9;

  logic       clk = 1'b0;
  logic       rst, load, start, tick;
  logic [3:0] load_min;
  logic [3:0] min_bcd, sec_tens, sec_ones, tenths;
  logic       running, expired, time_up;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] te;
    logic       run;
    logic       exp;
    logic       tu;
  } obs_t;

  obs_t expQ[$];
  int   nCmp = 0;
  int   nBad = 0;
  int   cyc  = 0;

  // Reference model: total tenths remaining and a mode number.
  int mCnt  = 0;
  int mMode = 0; // 0 idle, 1 run, 2 pause, 3 expired

  game_countdown #(.MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .load(load), .load_min(load_min), .start(start),
    .tick(tick), .min_bcd(min_bcd), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .tenths(tenths), .running(running), .expired(expired), .time_up(time_up)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model and queue its prediction.
  task automatic step(input logic r, input logic l, input logic [3:0] lm,
                      input logic s, input logic t);
    obs_t e;
    logic tu;
    @(negedge clk);
    rst = r; load = l; load_min = lm; start = s; tick = t;
    tu = 1'b0;
    if (r) begin
      mCnt = 0; mMode = 0;
    end else if (l) begin
      mCnt = ((int'(lm) > MAX_MIN) ? MAX_MIN : int'(lm)) * 600; mMode = 0;
    end else if (s) begin
      if (mMode == 0 && mCnt > 0) mMode = 1;
      else if (mMode == 1)        mMode = 2;
      else if (mMode == 2)        mMode = 1;
    end else if (t && mMode == 1 && mCnt > 0) begin
      mCnt = mCnt - 1;
      if (mCnt == 0) begin
        mMode = 3; tu = 1'b1;
      end
    end
    e.m   = 4'(mCnt / 600);
    e.st  = 4'((mCnt % 600) / 100);
    e.so  = 4'((mCnt % 100) / 10);
    e.te  = 4'(mCnt % 10);
    e.run = (mMode == 1);
    e.exp = (mMode == 3);
    e.tu  = tu;
    expQ.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic doLoad(input logic [3:0] lm);
    step(1'b0, 1'b1, lm, 1'b0, 1'b0);
  endtask

  task automatic doStart();
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  // Monitor: outputs are registered, so each edge presents one result.
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    cyc++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = {min_bcd, sec_tens, sec_ones, tenths, running, expired, time_up};
      nCmp++;
      if (a !== e) begin
        nBad++;
        $display("FAIL outputs@cycle%0d: got %0d:%0d%0d.%0d run=%b exp=%b tu=%b, want %0d:%0d%0d.%0d run=%b exp=%b tu=%b",
                 cyc, a.m, a.st, a.so, a.te, a.run, a.exp, a.tu,
                 e.m, e.st, e.so, e.te, e.run, e.exp, e.tu);
      end
    end
  end

  initial begin
    int unsigned rn;
    logic [3:0] lm;
    rst = 1'b0; load = 1'b0; load_min = 4'd0; start = 1'b0; tick = 1'b0;

    // Reset, then 3:00.0 running for 10 ticks -> 2:59.0.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    doLoad(4'd3); doStart(); ticks(10);

    // 1:00.0 to expiry, then extra ticks must do nothing.
    doLoad(4'd1); doStart(); ticks(600); ticks(5);
    doStart(); ticks(2);

    // Pause holds, resume continues.
    doLoad(4'd2); doStart(); ticks(5); doStart(); ticks(20); doStart(); ticks(1);

    // start+tick together in RUN pauses without counting; non-BCD load clamps.
    doLoad(4'd1); doStart();
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    ticks(3);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); // resume, tick discarded
    ticks(2);
    doLoad(4'hC);
    doLoad(4'hF);

    // Load beats start and tick in the same cycle.
    doStart(); ticks(4);
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);

    // Start with zero count stays idle.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    doLoad(4'd0); doStart(); ticks(3);

    // Reset alongside the final tick suppresses time_up.
    doLoad(4'd1); doStart(); ticks(599);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    ticks(3);

    // Random traffic, biased to small presets so expiry is reached.
    for (int i = 0; i < 30000; i++) begin
      rn = $urandom_range(0, 9999);
      lm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 1));
      step(rn < 3, $urandom_range(0, 799) == 0, lm,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      nBad++;
      $display("FAIL drain: %0d predictions left, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
